fm_tune_scan_ctrl: RTL and testbench
====================================

// Module: fm_tune_scan_ctrl
// PURPOSE
//  Channel-scan / tuning sequencer for the FM demodulator. Steps the NCO phase
//  increment (phi_inc) across NUM channels. For each channel it waits for the
//  mixer/FIR pipeline to settle, then measures baseband level from filtered I/Q.
//  When the scan ends it retunes phi_inc to the strongest channel and flags lock
//  if that channel's level clears a squelch threshold.
// PARAMETERS
//  SETTLE_CYC  32  cycles waited after every phi_inc change (FIR group delay + NCO)
//  MEAS_LOG2   6   log2 of samples averaged per channel (one sample per clk)
//  CH_W        8   width of channel count/index
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      pulse: begin scan (ignored unless IDLE)
//  abort      in   1      pulse: stop scan, return to IDLE
//  phi_start  in   32     phi_inc for channel 0 (sampled on accepted start)
//  phi_step   in   32     phi_inc increment per channel (sampled on accepted start)
//  num_ch     in   CH_W   channels to scan (sampled on accepted start)
//  squelch    in   18     minimum level for lock
//  I_in       in   16s    filtered baseband I
//  Q_in       in   16s    filtered baseband Q
//  phi_inc    out  32     NCO phase increment
//  busy       out  1      high in any state except IDLE
//  done       out  1      1-cycle pulse when scan completes (not on abort)
//  locked     out  1      best level >= squelch; cleared on start/abort
//  best_ch    out  CH_W   index of strongest channel
//  best_phi   out  32     phi_inc of strongest channel
//  best_lvl   out  18     level of strongest channel
// BEHAVIOUR
//  Reset: state=IDLE; phi_inc=0; busy=done=locked=0; best_ch=0; best_phi=0; best_lvl=0.
//  Level per sample m = |I|+|Q|; |-32768|=32768, no wrap (17b each, 18b sum).
//  acc width 18+MEAS_LOG2 (cannot overflow); lvl = acc>>MEAS_LOG2 (18b, truncate).
//  FSM:
//   IDLE   : start (abort low) -> TUNE; latch params; clear locked, best_lvl=0,
//            best_ch=0, best_phi=phi_start.
//   TUNE   : phi_inc<=phi_start, ch_idx<=0; num_ch==0 -> DONE, else -> SETTLE.
//   SETTLE : count SETTLE_CYC cycles (SETTLE_CYC=0 -> 1 cycle) -> MEAS; acc<=0.
//   MEAS   : acc+=m every cycle for 2^MEAS_LOG2 cycles -> CMP.
//   CMP    : lvl>best_lvl (strict: ties keep lower index; ch 0 always taken) ->
//            update best_*; ch_idx==num_ch-1 -> DONE else -> NEXT.
//   NEXT   : phi_inc<=phi_inc+phi_step (mod 2^32 wrap), ch_idx++ -> SETTLE.
//   DONE   : phi_inc<=best_phi; done=1 for this cycle; locked<=(best_lvl>=squelch);
//            -> IDLE.
//  Cycles from accepted start to done: 1 + num_ch*(SETTLE_CYC+2^MEAS_LOG2+2).
//  done/locked/phi_inc/best_* registered. locked/best_* hold in IDLE until next start.
//  abort in any non-IDLE state -> IDLE next cycle: phi_inc holds current value,
//   locked=0, no done; best_* keep partial results.
//  abort has priority over start and every transition. start while busy ignored.
//  rst mid-scan: all registers to reset values next cycle.
// TESTING
//  T1 SETTLE=4,M=3; start=0x10000000, step=0x01000000, num_ch=4; I/Q per ch
//     (100,0),(0,-300),(200,200),(-50,0) -> done at cycle 1+4*14=57; best_ch=2,
//     best_lvl=400, best_phi=phi_inc=0x12000000; squelch=300 -> locked=1.
//  T2 equal levels 250 on ch1 and ch3 (others 10), squelch=300 -> best_ch=1,
//     locked=0, phi_inc=start+step.
//  T3 I=Q=-32768 constant -> best_lvl=65536 exactly; step=0x80000000 from
//     0xC0000000 wraps to 0x40000000.
//  T4 num_ch=0 -> done 2 cycles after start; phi_inc=phi_start; best_lvl=0.
//  T5 abort in MEAS of ch2 -> busy=0 next cycle, no done, locked=0; start during
//     scan ignored (params unchanged, timing as T1).
//  T6 rst in NEXT -> all outputs reset values next cycle; new start scans normally.

Source files
------------

// File: rtl/fm_tune_scan_ctrl.sv
// Channel-scan / tuning sequencer. Steps the NCO phase increment across channels,
// averages |I|+|Q| per channel and retunes to the strongest one when the scan ends.
module fm_tune_scan_ctrl #(
  parameter int SETTLE_CYC = 32,
  parameter int MEAS_LOG2  = 6,
  parameter int CH_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        phi_start,
  input  logic [31:0]        phi_step,
  input  logic [CH_W-1:0]    num_ch,
  input  logic [17:0]        squelch,
  input  logic signed [15:0] I_in,
  input  logic signed [15:0] Q_in,
  output logic [31:0]        phi_inc,
  output logic               busy,
  output logic               done,
  output logic               locked,
  output logic [CH_W-1:0]    best_ch,
  output logic [31:0]        best_phi,
  output logic [17:0]        best_lvl
);

  localparam int MEAS_N      = 1 << MEAS_LOG2;
  localparam int ACC_W       = 18 + MEAS_LOG2;
  localparam int CNT_MAX     = (SETTLE_CYC > MEAS_N) ? SETTLE_CYC : MEAS_N;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  // A zero settle time still spends one cycle in SETTLE.
  localparam int SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int MEAS_LAST   = MEAS_N - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TUNE, S_SETTLE, S_MEAS, S_CMP, S_NEXT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      phi_start_q, phi_start_d;
  logic [31:0]      phi_step_q, phi_step_d;
  logic [CH_W-1:0]  num_ch_q, num_ch_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      phi_inc_q, phi_inc_d;
  logic             done_q, done_d;
  logic             locked_q, locked_d;
  logic [CH_W-1:0]  best_ch_q, best_ch_d;
  logic [31:0]      best_phi_q, best_phi_d;
  logic [17:0]      best_lvl_q, best_lvl_d;

  // |x| in 17 bits so that |-32768| = 32768 without wrapping.
  logic signed [16:0] i_ext, q_ext;
  logic [16:0]        abs_i, abs_q;
  logic [17:0]        sample_lvl;
  logic [17:0]        lvl;
  logic               settle_end, meas_end, last_ch;

  assign i_ext      = {I_in[15], I_in};
  assign q_ext      = {Q_in[15], Q_in};
  assign abs_i      = i_ext[16] ? 17'(-i_ext) : 17'(i_ext);
  assign abs_q      = q_ext[16] ? 17'(-q_ext) : 17'(q_ext);
  assign sample_lvl = {1'b0, abs_i} + {1'b0, abs_q};
  assign lvl        = acc_q[ACC_W-1:MEAS_LOG2];
  assign settle_end = (cnt_q == CNT_W'(SETTLE_LAST));
  assign meas_end   = (cnt_q == CNT_W'(MEAS_LAST));
  assign last_ch    = (ch_idx_q == num_ch_q - CH_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start && !abort) state_d = S_TUNE;
        S_TUNE:   state_d = (num_ch_q == '0) ? S_DONE : S_SETTLE;
        S_SETTLE: if (settle_end) state_d = S_MEAS;
        S_MEAS:   if (meas_end) state_d = S_CMP;
        S_CMP:    state_d = last_ch ? S_DONE : S_NEXT;
        S_NEXT:   state_d = S_SETTLE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    phi_start_d = phi_start_q;
    phi_step_d  = phi_step_q;
    num_ch_d    = num_ch_q;
    ch_idx_d    = ch_idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    phi_inc_d   = phi_inc_q;
    done_d      = 1'b0;
    locked_d    = locked_q;
    best_ch_d   = best_ch_q;
    best_phi_d  = best_phi_q;
    best_lvl_d  = best_lvl_q;
    if (abort) begin
      // Abort leaves phi_inc and the partial best_* results untouched.
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          phi_start_d = phi_start;
          phi_step_d  = phi_step;
          num_ch_d    = num_ch;
          locked_d    = 1'b0;
          best_lvl_d  = '0;
          best_ch_d   = '0;
          best_phi_d  = phi_start;
        end
        S_TUNE: begin
          phi_inc_d = phi_start_q;
          ch_idx_d  = '0;
          cnt_d     = '0;
          done_d    = (num_ch_q == '0);
        end
        S_SETTLE: begin
          if (settle_end) begin
            cnt_d = '0;
            acc_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_MEAS: begin
          acc_d = acc_q + ACC_W'(sample_lvl);
          cnt_d = meas_end ? '0 : cnt_q + CNT_W'(1);
        end
        S_CMP: begin
          // Strict compare keeps the lower index on ties; channel 0 seeds the search.
          if (ch_idx_q == '0 || lvl > best_lvl_q) begin
            best_ch_d  = ch_idx_q;
            best_phi_d = phi_inc_q;
            best_lvl_d = lvl;
          end
          done_d = last_ch;
        end
        S_NEXT: begin
          phi_inc_d = phi_inc_q + phi_step_q;
          ch_idx_d  = ch_idx_q + CH_W'(1);
          cnt_d     = '0;
        end
        S_DONE: begin
          phi_inc_d = best_phi_q;
          locked_d  = (best_lvl_q >= squelch);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phi_start_q <= '0;
      phi_step_q  <= '0;
      num_ch_q    <= '0;
      ch_idx_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      phi_inc_q   <= '0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      best_ch_q   <= '0;
      best_phi_q  <= '0;
      best_lvl_q  <= '0;
    end else begin
      phi_start_q <= phi_start_d;
      phi_step_q  <= phi_step_d;
      num_ch_q    <= num_ch_d;
      ch_idx_q    <= ch_idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      phi_inc_q   <= phi_inc_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      best_ch_q   <= best_ch_d;
      best_phi_q  <= best_phi_d;
      best_lvl_q  <= best_lvl_d;
    end
  end

  assign phi_inc  = phi_inc_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign locked   = locked_q;
  assign best_ch  = best_ch_q;
  assign best_phi = best_phi_q;
  assign best_lvl = best_lvl_q;

endmodule

// File: tb/tb_fm_tune_scan_ctrl.sv
// Bench for fm_tune_scan_ctrl: table-driven scans, random scans against a
// channel-level model, plus abort / reset / start-while-busy sequences.
module tb_fm_tune_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int MLOG   = 3;
  localparam int MN     = 1 << MLOG;
  localparam int PER_CH = SETTLE + MN + 2;
  localparam int CHW    = 8;
  localparam int NCYC   = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [31:0]       phi_start = '0;
  logic [31:0]       phi_step = '0;
  logic [CHW-1:0]    num_ch = '0;
  logic [17:0]       squelch = '0;
  logic signed [15:0] I_in = '0;
  logic signed [15:0] Q_in = '0;
  logic [31:0]       phi_inc;
  logic              busy, done, locked;
  logic [CHW-1:0]    best_ch;
  logic [31:0]       best_phi;
  logic [17:0]       best_lvl;

  fm_tune_scan_ctrl #(.SETTLE_CYC(SETTLE), .MEAS_LOG2(MLOG), .CH_W(CHW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .phi_start(phi_start), .phi_step(phi_step), .num_ch(num_ch), .squelch(squelch),
    .I_in(I_in), .Q_in(Q_in), .phi_inc(phi_inc), .busy(busy), .done(done),
    .locked(locked), .best_ch(best_ch), .best_phi(best_phi), .best_lvl(best_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      ps;
    logic [31:0]      st;
    int               nch;
    logic [17:0]      sq;
    logic [3:0][15:0] ci;
    logic [3:0][15:0] cq;
    int               ech;
    int               elvl;
    logic [31:0]      ephi;
    bit               elock;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [15:0] iv [NCYC];
  logic signed [15:0] qv [NCYC];
  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ps, input logic [31:0] st, input int nch,
                              input int sq, input int i0, input int q0, input int i1,
                              input int q1, input int i2, input int q2, input int i3,
                              input int q3, input int ech, input int elvl,
                              input logic [31:0] ephi, input bit elock);
    vec_t v;
    v.ps = ps; v.st = st; v.nch = nch; v.sq = 18'(sq);
    v.ci[0] = 16'(i0); v.cq[0] = 16'(q0); v.ci[1] = 16'(i1); v.cq[1] = 16'(q1);
    v.ci[2] = 16'(i2); v.cq[2] = 16'(q2); v.ci[3] = 16'(i3); v.cq[3] = 16'(q3);
    v.ech = ech; v.elvl = elvl; v.ephi = ephi; v.elock = elock;
    return v;
  endfunction

  function automatic int iabs(input logic signed [15:0] x);
    int t;
    t = int'(x);
    return (t < 0) ? -t : t;
  endfunction

  // Reference: average of |I|+|Q| over each channel's measurement window,
  // first channel always taken, later ones only when strictly louder.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int sum, lvl, base;
    r = v;
    r.ech = 0; r.elvl = 0; r.ephi = v.ps;
    for (int k = 0; k < v.nch; k++) begin
      base = 2 + SETTLE + PER_CH * k;
      sum = 0;
      for (int j = 0; j < MN; j++) sum += iabs(iv[base + j]) + iabs(qv[base + j]);
      lvl = sum / MN;
      if (k == 0 || lvl > r.elvl) begin
        r.ech = k; r.elvl = lvl; r.ephi = 32'(v.ps + v.st * 32'(k));
      end
    end
    return r;
  endfunction

  task automatic fill_const(input vec_t v);
    int k;
    for (int c = 0; c < NCYC; c++) begin
      k = (c < 2) ? 0 : (c - 2) / PER_CH;
      if (k > 3) k = 3;
      iv[c] = v.ci[k];
      qv[c] = v.cq[k];
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < NCYC; c++) begin
      iv[c] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
      qv[c] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
    end
  endtask

  // One full scan; params on the inputs are scrambled after the start is taken
  // and a stray start is pulsed mid-scan, neither of which may change the result.
  task automatic run_scan(input vec_t v, input string tag);
    int exp_done;
    int early;
    exp_done = (v.nch == 0) ? 2 : 1 + PER_CH * v.nch;
    early = 0;
    @(negedge clk);
    phi_start = v.ps; phi_step = v.st; num_ch = CHW'(v.nch); squelch = v.sq;
    start = 1'b1; I_in = iv[0]; Q_in = qv[0];
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " busy_after_start"}, 64'(busy), 64'(1));
      if (c < exp_done && done) early++;
      for (int k = 0; k < v.nch; k++)
        if (c == 2 + SETTLE + PER_CH * k)
          check({tag, " phi_inc_ch"}, 64'(phi_inc), 64'(32'(v.ps + v.st * 32'(k))));
      if (c == exp_done) begin
        check({tag, " done"}, 64'(done), 64'(1));
        check({tag, " best_ch"}, 64'(best_ch), 64'(v.ech));
        check({tag, " best_lvl"}, 64'(best_lvl), 64'(v.elvl));
        check({tag, " best_phi"}, 64'(best_phi), 64'(v.ephi));
      end
      if (c == exp_done + 1) begin
        check({tag, " done_pulse_end"}, 64'(done), 64'(0));
        check({tag, " busy_idle"}, 64'(busy), 64'(0));
        check({tag, " phi_inc_final"}, 64'(phi_inc), 64'(v.ephi));
        check({tag, " locked"}, 64'(locked), 64'(v.elock));
      end
      start = (c == 3 && exp_done > 4);
      phi_start = $urandom; phi_step = $urandom; num_ch = CHW'($urandom);
      I_in = iv[c]; Q_in = qv[c];
    end
    start = 1'b0;
    check({tag, " no_early_done"}, 64'(early), 64'(0));
    $display("%s: nch=%0d best_ch=%0d best_lvl=%0d best_phi=0x%08h phi_inc=0x%08h locked=%0b",
             tag, v.nch, best_ch, best_lvl, best_phi, phi_inc, locked);
  endtask

  initial begin
    vec_t rv;
    int dones;
    tbl[0] = mk(32'h1000_0000, 32'h0100_0000, 4, 300, 100, 0, 0, -300, 200, 200, -50, 0,
                2, 400, 32'h1200_0000, 1'b1);
    tbl[1] = mk(32'h2000_0000, 32'h0010_0000, 4, 300, 10, 0, 125, -125, 0, 10, -250, 0,
                1, 250, 32'h2010_0000, 1'b0);
    tbl[2] = mk(32'hC000_0000, 32'h8000_0000, 2, 65536, 0, 0, -32768, -32768, 0, 0, 0, 0,
                1, 65536, 32'h4000_0000, 1'b1);
    tbl[3] = mk(32'h0ABC_DEF0, 32'h0000_1000, 0, 5, 1000, 1000, 0, 0, 0, 0, 0, 0,
                0, 0, 32'h0ABC_DEF0, 1'b0);
    tbl[4] = mk(32'h0000_0100, 32'h0000_0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'h0000_0100, 1'b1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset phi_inc", 64'(phi_inc), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset locked", 64'(locked), 64'(0));
    check("reset best_ch", 64'(best_ch), 64'(0));
    check("reset best_phi", 64'(best_phi), 64'(0));
    check("reset best_lvl", 64'(best_lvl), 64'(0));

    for (int t = 0; t < 5; t++) begin
      fill_const(tbl[t]);
      run_scan(tbl[t], $sformatf("table%0d", t));
    end

    // abort takes priority over a simultaneous start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start busy", 64'(busy), 64'(0));

    // abort during channel 2 measurement
    fill_const(tbl[0]);
    @(negedge clk);
    phi_start = tbl[0].ps; phi_step = tbl[0].st; num_ch = CHW'(tbl[0].nch);
    squelch = tbl[0].sq; start = 1'b1; I_in = iv[0]; Q_in = qv[0];
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      start = 1'b0; I_in = iv[c]; Q_in = qv[c];
      abort = (c == 2 + SETTLE + 2 * PER_CH + 2);
    end
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort locked", 64'(locked), 64'(0));
    check("abort phi_inc_hold", 64'(phi_inc), 64'(32'h1200_0000));
    check("abort best_ch", 64'(best_ch), 64'(1));
    check("abort best_lvl", 64'(best_lvl), 64'(300));
    check("abort best_phi", 64'(best_phi), 64'(32'h1100_0000));
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort stays_idle", 64'(dones), 64'(0));
    $display("abort: best_ch=%0d best_lvl=%0d phi_inc=0x%08h", best_ch, best_lvl, phi_inc);

    // synchronous reset while in NEXT after channel 0
    @(negedge clk);
    phi_start = tbl[0].ps; phi_step = tbl[0].st; num_ch = CHW'(tbl[0].nch);
    start = 1'b1;
    for (int c = 1; c <= 1 + SETTLE + MN + 2; c++) begin
      @(negedge clk);
      start = 1'b0; I_in = iv[c]; Q_in = qv[c];
      rst = (c == 1 + SETTLE + MN + 2);
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst phi_inc", 64'(phi_inc), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst best_ch", 64'(best_ch), 64'(0));
    check("midrst best_phi", 64'(best_phi), 64'(0));
    check("midrst best_lvl", 64'(best_lvl), 64'(0));
    $display("midrst: phi_inc=0x%08h best_lvl=%0d", phi_inc, best_lvl);
    run_scan(tbl[0], "after_rst");

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      rv = mk($urandom, $urandom, $urandom_range(1, 6), 0, 0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 32'h0, 1'b0);
      rv = model(rv);
      rv.sq = 18'(rv.elvl + int'($urandom_range(0, 1)));
      rv.elock = (rv.elvl >= int'(rv.sq));
      run_scan(rv, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
